regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module : regfile_param
// Two-read/one-write register file with reservation scoreboard, write bypass
// and a sequential bulk-clear engine.
// Rev    : 1.0
// ============================================================================
module regfile_param #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [WIDTH-1:0]  rd_data1,
   output logic [WIDTH-1:0]  rd_data2,
   output logic              rd_pend1,
   output logic              rd_pend2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              wr_ready,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              clr_req,
   output logic              clr_done
);

   localparam int                DEPTH      = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] C_ONE      = ADDR_W'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [WIDTH-1:0]    mem_d [DEPTH];
   logic [DEPTH-1:0]    pend_q, pend_d;

   logic                w_idle;
   logic                w_commit;
   logic                w_rsv;
   logic                w_clr_done;
   logic [1:0][ADDR_W-1:0] w_rd_addr;

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Writes and reservations are only honoured in IDLE; the zero register
   // swallows both so it never holds data or a pending mark.
   assign w_idle   = (state_q == S_IDLE);
   assign w_commit = wr_en  && w_idle && !is_zero_reg(wr_addr);
   assign w_rsv    = rsv_en && w_idle && !is_zero_reg(rsv_addr);

   assign w_rd_addr = {rd_addr2, rd_addr1};

   generate
      for (genvar p = 0; p < 2; p++) begin : g_rd_port
         logic [WIDTH-1:0] w_data;
         logic             w_pend;

         always_comb begin
            w_data = mem_q[w_rd_addr[p]];
            w_pend = pend_q[w_rd_addr[p]];
            if (is_zero_reg(w_rd_addr[p])) begin
               w_data = '0;
               w_pend = 1'b0;
            end else if (w_commit && (wr_addr == w_rd_addr[p])) begin
               w_data = wr_data;
            end
         end
      end
   endgenerate

   assign rd_data1 = g_rd_port[0].w_data;
   assign rd_data2 = g_rd_port[1].w_data;
   assign rd_pend1 = g_rd_port[0].w_pend;
   assign rd_pend2 = g_rd_port[1].w_pend;
   assign wr_ready = w_idle;
   assign clr_done = w_clr_done;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      w_clr_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clr_req) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            cnt_d = cnt_q + C_ONE;
            if (cnt_q == C_LAST_IDX) begin
               state_d    = S_IDLE;
               w_clr_done = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (w_commit) begin
         mem_d[wr_addr] = wr_data;
      end
      if (state_q == S_CLEAR) begin
         mem_d[cnt_q] = '0;
      end
   end

   // Reservation is applied after the write-side clear so a same-cycle
   // reserve of the written register leaves it pending.
   always_comb begin
      pend_d = pend_q;
      if (w_commit) begin
         pend_d[wr_addr] = 1'b0;
      end
      if (w_rsv) begin
         pend_d[rsv_addr] = 1'b1;
      end
      if (state_q == S_CLEAR) begin
         pend_d[cnt_q] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule
`default_nettype wire
